writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising clock edge.
REQ-003 control_signals_W  input  3  bit0 reg_write; bits[2:1] result_src (00 ALU, 01 memory, 10 PC+4, 11 reserved).
REQ-004 ALU_result_W  input  32  ALU result from writeback pipe register.
REQ-005 read_data_W  input  32  load data from writeback pipe register.
REQ-006 Rd_W  input  5  destination register index.
REQ-007 PC_4_W  input  32  return address for JAL/JALR.
REQ-008 Rs1_D  input  5  decode-stage read index, port 1.
REQ-009 Rs2_D  input  5  decode-stage read index, port 2.
REQ-010 read_data1_D  output  32  register value for Rs1_D.
REQ-011 read_data2_D  output  32  register value for Rs2_D.
REQ-012 result_W  output  32  selected writeback value, for hazard forwarding.
REQ-013 wb_count  output  32  count of committed register writes.

Function
REQ-014 result_W SHALL be combinational: ALU_result_W for src 00 or 11, read_data_W for 01, PC_4_W for 10.
REQ-015 Write commits on a rising edge when reg_write=1 and Rd_W!=0; x[Rd_W] <= result_W.
REQ-016 x0 SHALL always read 0; writes to x0 are discarded and do not increment wb_count.
REQ-017 Read ports SHALL be combinational (asynchronous) from storage; zero-cycle latency.
REQ-018 wb_count SHALL increment by 1 on each committed write (REQ-015) and wrap 0xFFFFFFFF -> 0 without flag.
REQ-019 reg_write=0: storage and wb_count unchanged regardless of other inputs.
REQ-020 Rs1_D==Rs2_D SHALL return identical values on both ports.
REQ-021 result_src=11 SHALL behave exactly as 00 (no error, no stall).

Reset
REQ-022 reset=1 at a rising edge SHALL clear x1..x31 and wb_count to 0.
REQ-023 Reset SHALL take priority over a simultaneous write; that write is lost and not counted.
REQ-024 During reset, read ports reflect storage (0 after first reset edge); result_W stays combinational.
REQ-025 Storage contents before the first reset edge are undefined; verification SHALL not check them.

Configuration
REQ-026 Macro WB_BYPASS_EN: when defined, a read whose index equals Rd_W with reg_write=1 and Rd_W!=0 SHALL return result_W in the same cycle (write-through).
REQ-027 Without WB_BYPASS_EN, reads SHALL return stored value only; the new value appears the cycle after the commit edge.
REQ-028 Bypass SHALL never apply to index 0, and SHALL be suppressed while reset=1.

Structure
REQ-029 Shared package wb_pkg SHALL hold XLEN=32, NREGS=32, reg_write bit index, result_src field position and an enum for the four result_src codes.
REQ-030 Storage SHALL be a sub-module regfile_array (31x32, one write port, two async read ports, sync clear); mux, bypass and counter live in writeback_regfile.

Verification
REQ-031 Reset then read all 32 indices -> every value 0, wb_count=0.
REQ-032 ctrl=3'b001, Rd=5, ALU=0x12345678 -> next cycle Rs1_D=5 reads 0x12345678, wb_count=1; ctrl=3'b011 read_data=0xCAFEF00D Rd=6 -> x6=0xCAFEF00D; ctrl=3'b101 PC_4=0x00000104 Rd=1 -> x1=0x104.
REQ-033 ctrl=3'b001, Rd=0, ALU=0xFFFFFFFF -> x0 reads 0, wb_count unchanged.
REQ-034 Same-cycle write Rd=7 value 0xA5A5A5A5 with Rs2_D=7 -> 0xA5A5A5A5 combinationally with WB_BYPASS_EN, previous x7 without it.
REQ-035 Write Rd=9 value 0x55 while reset=1 -> x9=0, wb_count=0 after edge.
REQ-036 Force wb_count to 0xFFFFFFFE via 0xFFFFFFFE writes (or backdoor), two more writes -> wb_count=0x00000000.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage and its register file.
package wb_pkg;
    localparam int XLEN           = 32;
    localparam int NREGS          = 32;
    localparam int AW             = $clog2(NREGS);
    localparam int REG_WRITE_BIT  = 0;
    localparam int RESULT_SRC_LSB = 1;
    localparam int RESULT_SRC_W   = 2;

    typedef enum logic [RESULT_SRC_W-1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_RSVD = 2'b11
    } result_src_e;
endpackage

// File: rtl/regfile_array.sv
// Integer register storage x1..x31: one write port, two asynchronous read ports,
// synchronous clear. Index 0 is not stored and always reads as zero.
module regfile_array
    import wb_pkg::*;
(
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [AW-1:0]   raddr  [2];
    logic [XLEN-1:0] rdata  [2];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs_q[raddr[gi]];
        end
    endgenerate

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];
endmodule

// File: rtl/writeback_regfile.sv
// Writeback result mux, register file and committed-write counter.
// Define WB_BYPASS_EN to make same-cycle reads of the register being written return result_W.
module writeback_regfile
    import wb_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [2:0]      control_signals_W,
    input  logic [XLEN-1:0] ALU_result_W,
    input  logic [XLEN-1:0] read_data_W,
    input  logic [AW-1:0]   Rd_W,
    input  logic [XLEN-1:0] PC_4_W,
    input  logic [AW-1:0]   Rs1_D,
    input  logic [AW-1:0]   Rs2_D,
    output logic [XLEN-1:0] read_data1_D,
    output logic [XLEN-1:0] read_data2_D,
    output logic [XLEN-1:0] result_W,
    output logic [XLEN-1:0] wb_count
);
    logic            reg_write;
    result_src_e     result_src;
    logic            commit;
    logic [XLEN-1:0] result_sel;
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;
    logic [XLEN-1:0] wb_count_q;
    logic [XLEN-1:0] wb_count_d;

    assign reg_write  = control_signals_W[REG_WRITE_BIT];
    assign result_src = result_src_e'(control_signals_W[RESULT_SRC_LSB +: RESULT_SRC_W]);

    // The reserved code falls through to the ALU path.
    always_comb begin
        result_sel = ALU_result_W;
        case (result_src)
            SRC_MEM: result_sel = read_data_W;
            SRC_PC4: result_sel = PC_4_W;
            default: result_sel = ALU_result_W;
        endcase
    end

    assign result_W = result_sel;
    assign commit   = reg_write && (Rd_W != '0);

    regfile_array u_array (
        .clk_i    (clock),
        .srst_i   (reset),
        .we_i     (commit),
        .waddr_i  (Rd_W),
        .wdata_i  (result_sel),
        .raddr1_i (Rs1_D),
        .raddr2_i (Rs2_D),
        .rdata1_o (stored1),
        .rdata2_o (stored2)
    );

`ifdef WB_BYPASS_EN
    // commit already excludes x0, so the bypass can never expose a write to x0.
    assign read_data1_D = (commit && !reset && (Rs1_D == Rd_W)) ? result_sel : stored1;
    assign read_data2_D = (commit && !reset && (Rs2_D == Rd_W)) ? result_sel : stored2;
`else
    assign read_data1_D = stored1;
    assign read_data2_D = stored2;
`endif

    assign wb_count_d = commit ? wb_count_q + 1'b1 : wb_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;
endmodule
